// File: rtl/mul_if.sv
// mul_if: handshake and operand/result bundle between the main control FSM (master) and the multiply sequencer (slave).
interface mul_if #(parameter int WIDTH = 32);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             busy;
   logic             stall;
   logic             done;
   logic [WIDTH-1:0] result_lo;
   logic [WIDTH-1:0] result_hi;
   modport master (output start, op, src_a, src_b, input busy, stall, done, result_lo, result_hi);
   modport slave (input start, op, src_a, src_b, output busy, stall, done, result_lo, result_hi);
endinterface

// File: rtl/mul_sequencer.sv
// mul_sequencer: radix-2 shift-add MUL/UMULL/SMULL engine over WIDTH cycles.
// Optional MUL_EARLY_TERM_EN ends RUN as soon as the remaining multiplier bits are all zero.
module mul_sequencer #(parameter int WIDTH = 32) (
   input logic   clk,
   input logic   reset,
   mul_if.slave  bus
);
   localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3;
   logic [1:0]         state;
   logic [2*WIDTH-1:0] acc, ma, sum, fixed;
   logic [WIDTH-1:0]   mb, abs_a, abs_b;
   logic [CW-1:0]      cnt;
   logic               neg, smull, a_neg, b_neg, last;
   assign smull = bus.op == 2'b10;
   assign a_neg = smull & bus.src_a[WIDTH-1];
   assign b_neg = smull & bus.src_b[WIDTH-1];
   assign abs_a = a_neg ? -bus.src_a : bus.src_a;
   assign abs_b = b_neg ? -bus.src_b : bus.src_b;
   assign sum = mb[0] ? acc + ma : acc;
   assign fixed = neg ? -acc : acc;
`ifdef MUL_EARLY_TERM_EN
   assign last = (mb >> 1) == '0 || cnt == CW'(WIDTH - 1);
`else
   assign last = cnt == CW'(WIDTH - 1);
`endif
   assign bus.busy = state != IDLE;
   assign bus.done = state == DONE;
   assign bus.stall = bus.busy | (bus.start & state == IDLE);
   // ma is kept pre-shifted so each RUN step adds ma << cnt without a barrel shifter
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= IDLE;
         acc <= '0;
         ma <= '0;
         mb <= '0;
         cnt <= '0;
         neg <= 1'b0;
         bus.result_lo <= '0;
         bus.result_hi <= '0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               ma <= {{WIDTH{1'b0}}, abs_a};
               mb <= abs_b;
               neg <= (|bus.src_a) & (|bus.src_b) & (a_neg ^ b_neg);
               acc <= '0;
               cnt <= '0;
               state <= RUN;
            end
            RUN: begin
               acc <= sum;
               ma <= ma << 1;
               mb <= mb >> 1;
               cnt <= cnt + 1'b1;
               if (last) state <= FIX;
            end
            // results are registered on entry to DONE so they are valid while done is high
            FIX: begin
               acc <= fixed;
               {bus.result_hi, bus.result_lo} <= fixed;
               state <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: directed and random checks of mul_sequencer against a plain-arithmetic product model.
// Define MUL_EARLY_TERM_EN for both files to check the early-termination latency.
module tb_mul_sequencer;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;
   mul_if #(.WIDTH(32)) bus ();
   mul_sequencer #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
`ifdef MUL_EARLY_TERM_EN
   localparam bit ET = 1'b1;
`else
   localparam bit ET = 1'b0;
`endif
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return op == 2'b10 ? 64'(sa * sb) : {32'd0, a} * {32'd0, b};
   endfunction
   function automatic int latency(input logic [1:0] op, input logic [31:0] b);
      logic [31:0] m;
      int n;
      m = (op == 2'b10 && b[31]) ? -b : b;
      n = 1;
      for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
      return ET ? n + 2 : 34;
   endfunction
   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int p1, input int p2);
      logic [63:0] exp, got;
      int seen, ndone;
      exp = model(op, a, b);
      got = '0;
      seen = 0;
      ndone = 0;
      bus.op = op;
      bus.src_a = a;
      bus.src_b = b;
      bus.start = 1'b1;
      @(negedge clk);
      check({tag, " stall0"}, 64'(bus.stall), 64'd1);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.op = 2'($urandom);
      bus.src_a = $urandom;
      bus.src_b = $urandom;
      for (int k = 1; k <= 40; k++) begin
         bus.start = (k == p1 || k == p2);
         @(negedge clk);
         if (k == 1) check({tag, " busy1"}, 64'(bus.busy), 64'd1);
         if (bus.done) begin
            ndone++;
            if (seen == 0) begin
               seen = k;
               got = {bus.result_hi, bus.result_lo};
            end
         end
         @(posedge clk);
         #1;
      end
      bus.start = 1'b0;
      check({tag, " done_cycle"}, 64'(seen), 64'(latency(op, b)));
      check({tag, " done_count"}, 64'(ndone), 64'd1);
      check({tag, " product"}, got, exp);
      check({tag, " held"}, {bus.result_hi, bus.result_lo}, exp);
   endtask
   initial begin
      logic [31:0] a, b;
      logic [1:0] op;
      int ndone;
      bus.start = 1'b0;
      bus.op = 2'b00;
      bus.src_a = '0;
      bus.src_b = '0;
      repeat (2) @(negedge clk);
      check("reset busy", 64'(bus.busy), 64'd0);
      check("reset done", 64'(bus.done), 64'd0);
      check("reset result", {bus.result_hi, bus.result_lo}, 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("idle stall", 64'(bus.stall), 64'd0);
      run_op("umull_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
      check("umull_max const", {bus.result_hi, bus.result_lo}, 64'hFFFFFFFE_00000001);
      run_op("smull_m1x2", 2'b10, 32'hFFFFFFFF, 32'h00000002, 0, 0);
      check("smull_m1x2 const", {bus.result_hi, bus.result_lo}, 64'hFFFFFFFF_FFFFFFFE);
      run_op("smull_min", 2'b10, 32'h80000000, 32'h80000000, 0, 0);
      check("smull_min const", {bus.result_hi, bus.result_lo}, 64'h40000000_00000000);
      run_op("mul_7x6", 2'b00, 32'd7, 32'd6, 0, 0);
      check("mul_7x6 const", {bus.result_hi, bus.result_lo}, 64'h2A);
      run_op("op11_7x6", 2'b11, 32'd7, 32'd6, 0, 0);
      check("op11_7x6 const", {bus.result_hi, bus.result_lo}, 64'h2A);
      run_op("busy_start", 2'b01, 32'h12345678, 32'h9ABCDEF0, 5, 20);
      run_op("umull_3x5", 2'b01, 32'd3, 32'd5, 0, 0);
      run_op("umull_x0", 2'b01, 32'hDEADBEEF, 32'd0, 0, 0);
      run_op("smull_neg0", 2'b10, 32'hFFFFFFF0, 32'd0, 0, 0);
      run_op("smull_pos_neg", 2'b10, 32'd1000, 32'hFFFFFC18, 0, 0);
      bus.op = 2'b01;
      bus.src_a = 32'hCAFEF00D;
      bus.src_b = 32'h87654321;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (9) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("midrun busy", 64'(bus.busy), 64'd0);
      check("midrun done", 64'(bus.done), 64'd0);
      check("midrun result", {bus.result_hi, bus.result_lo}, 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      ndone = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus.done) ndone++;
      end
      check("midrun no_done", 64'(ndone), 64'd0);
      @(posedge clk);
      #1;
      run_op("after_reset", 2'b01, 32'hCAFEF00D, 32'h87654321, 0, 0);
      for (int i = 0; i < 12; i++) begin
         op = 2'($urandom);
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: a = 32'h80000000;
            1: b = 32'd0;
            2: b = b >> $urandom_range(0, 31);
            default: ;
         endcase
         run_op($sformatf("rand%0d", i), op, a, b, 0, 0);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
